// File: rtl/ac_motor_phase_sequencer.sv
// Six-step commutation sequencer for a three-phase bridge: soft-started step rate,
// shared dead-time/enable for the per-phase switch-delay stages, and a safe drain on stop.
module ac_motor_phase_sequencer #(
    parameter int PERIOD_W  = 16,
    parameter int DELAY_W   = 11,
    parameter int RAMP_STEP = 16
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                enable,
    input  logic                dir,
    input  logic [PERIOD_W-1:0] period_start,
    input  logic [PERIOD_W-1:0] period_target,
    input  logic [DELAY_W-1:0]  delay_in,
    output logic                s_u,
    output logic                s_v,
    output logic                s_w,
    output logic                sd_enable,
    output logic [DELAY_W-1:0]  delay_out,
    output logic [2:0]          step_idx,
    output logic                step_pulse,
    output logic                busy
);

    localparam int CNT_W = (PERIOD_W > DELAY_W + 1) ? PERIOD_W : DELAY_W + 1;
    localparam logic [PERIOD_W:0] RAMP  = RAMP_STEP[PERIOD_W:0];
    localparam logic [PERIOD_W:0] P_MAX = {1'b0, {PERIOD_W{1'b1}}};
    localparam logic [PERIOD_W:0] P_MIN = (PERIOD_W + 1)'(2);

    typedef enum logic [1:0] {IDLE, START, RUN, STOP} state_t;

    state_t                state, state_nx;
    logic [CNT_W-1:0]      cnt, cnt_nx;
    logic [PERIOD_W-1:0]   cur_period, cur_period_nx;
    logic [2:0]            idx_nx;
    logic [2:0]            phase, phase_nx;
    logic [DELAY_W-1:0]    delay_nx;
    logic                  sd_nx, pulse_nx, busy_nx;
    logic [CNT_W-1:0]      period_last, drain_last;

    function automatic logic [PERIOD_W-1:0] clamp2(input logic [PERIOD_W-1:0] v);
        return (v < PERIOD_W'(2)) ? PERIOD_W'(2) : v;
    endfunction

    // One extra bit keeps cur +/- RAMP from wrapping before the target clamp.
    function automatic logic [PERIOD_W-1:0] ramp_toward(input logic [PERIOD_W-1:0] cur,
                                                        input logic [PERIOD_W-1:0] tgt);
        logic [PERIOD_W:0] c, t, r;
        c = {1'b0, cur};
        t = {1'b0, tgt};
        r = c;
        if (c < t)
            r = (t - c > RAMP) ? c + RAMP : t;
        else if (c > t)
            r = (c - t > RAMP) ? c - RAMP : t;
        if (r < P_MIN)
            r = P_MIN;
        else if (r > P_MAX)
            r = P_MAX;
        return r[PERIOD_W-1:0];
    endfunction

    function automatic logic [2:0] phase_of(input logic [2:0] idx);
        case (idx)
            3'd0:    return 3'b101;
            3'd1:    return 3'b100;
            3'd2:    return 3'b110;
            3'd3:    return 3'b010;
            3'd4:    return 3'b011;
            3'd5:    return 3'b001;
            default: return 3'b000;
        endcase
    endfunction

    assign period_last = CNT_W'(cur_period) - CNT_W'(1);
    assign drain_last  = CNT_W'(delay_out) + CNT_W'(1);
    assign {s_u, s_v, s_w} = phase;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            cnt        <= '0;
            cur_period <= PERIOD_W'(2);
            step_idx   <= 3'd0;
            phase      <= 3'b000;
            delay_out  <= '0;
            sd_enable  <= 1'b0;
            step_pulse <= 1'b0;
            busy       <= 1'b0;
        end else begin
            state      <= state_nx;
            cnt        <= cnt_nx;
            cur_period <= cur_period_nx;
            step_idx   <= idx_nx;
            phase      <= phase_nx;
            delay_out  <= delay_nx;
            sd_enable  <= sd_nx;
            step_pulse <= pulse_nx;
            busy       <= busy_nx;
        end
    end

    // Stop takes priority over a coincident step boundary so the bridge never advances while draining.
    always_comb begin
        state_nx      = state;
        cnt_nx        = cnt;
        cur_period_nx = cur_period;
        idx_nx        = step_idx;
        delay_nx      = delay_out;
        sd_nx         = sd_enable;
        pulse_nx      = 1'b0;
        case (state)
            IDLE: begin
                if (enable)
                    state_nx = START;
            end
            START: begin
                delay_nx      = delay_in;
                cur_period_nx = clamp2(period_start);
                idx_nx        = 3'd0;
                cnt_nx        = '0;
                sd_nx         = 1'b1;
                state_nx      = RUN;
            end
            RUN: begin
                if (!enable) begin
                    state_nx = STOP;
                    cnt_nx   = '0;
                end else if (cnt == period_last) begin
                    cnt_nx        = '0;
                    pulse_nx      = 1'b1;
                    delay_nx      = delay_in;
                    cur_period_nx = ramp_toward(cur_period, clamp2(period_target));
                    if (dir)
                        idx_nx = (step_idx == 3'd0) ? 3'd5 : step_idx - 3'd1;
                    else
                        idx_nx = (step_idx == 3'd5) ? 3'd0 : step_idx + 3'd1;
                end else begin
                    cnt_nx = cnt + CNT_W'(1);
                end
            end
            STOP: begin
                if (cnt == drain_last) begin
                    cnt_nx   = '0;
                    sd_nx    = 1'b0;
                    state_nx = IDLE;
                end else begin
                    cnt_nx = cnt + CNT_W'(1);
                end
            end
            default: state_nx = IDLE;
        endcase
        phase_nx = (state_nx == RUN) ? phase_of(idx_nx) : 3'b000;
        busy_nx  = (state_nx != IDLE);
    end

endmodule
